// File: rtl/mau_req_arbiter_4b.sv
// Shares one 4-bit MAU decode/ALU pipeline among NUM_REQ requesters; tags each issued command and
// steers the in-order results back. Define MAU_ARB_FIXED_PRIO_EN for strict lowest-index priority.
module mau_req_arbiter_4b #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [4*NUM_REQ-1:0]                   req_op,
    input  logic [4*NUM_REQ-1:0]                   req_a1,
    input  logic [4*NUM_REQ-1:0]                   req_a2,
    input  logic [4*NUM_REQ-1:0]                   req_b1,
    input  logic [4*NUM_REQ-1:0]                   req_b2,
    output logic                                   mau_valid,
    input  logic                                   mau_ready,
    output logic [3:0]                             mau_op,
    output logic [3:0]                             mau_a1,
    output logic [3:0]                             mau_a2,
    output logic [3:0]                             mau_b1,
    output logic [3:0]                             mau_b2,
    input  logic                                   alu_res_valid,
    input  logic [9:0]                             alu_res,
    input  logic                                   alu_carry,
    output logic                                   alu_res_ready,
    output logic [NUM_REQ-1:0]                     rsp_valid,
    input  logic [NUM_REQ-1:0]                     rsp_ready,
    output logic [9:0]                             rsp_data,
    output logic                                   rsp_carry,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   err_orphan
);

    localparam int unsigned TAG_W = $clog2(NUM_REQ);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [TAG_W-1:0]   rr_ptr;
    logic [TAG_W-1:0]   winner;
    logic               any_valid;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [TAG_W-1:0]   head_tag;
    logic [TAG_W-1:0]   tag_mem [MAX_OUTSTANDING];
    int                 cand;

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == CNT_W'(MAX_OUTSTANDING));
    assign head_tag    = tag_mem[rd_ptr];
    assign outstanding = count;
    assign mau_valid   = (state == S_FULL);

    // Round-robin pick: scan downward so the candidate closest to rr_ptr is written last and wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        cand      = 0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= int'(NUM_REQ)) begin
                cand = cand - int'(NUM_REQ);
            end
            if (req_valid[cand]) begin
                any_valid = 1'b1;
                winner    = TAG_W'(cand);
            end
        end
    end

    // Issue slot next-state; a capture is allowed when the slot is empty or being drained this cycle.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        req_ready  = '0;
        if (any_valid && !fifo_full && ((state == S_EMPTY) || mau_ready)) begin
            push              = 1'b1;
            req_ready[winner] = 1'b1;
            state_next        = S_FULL;
        end else if ((state == S_FULL) && mau_ready) begin
            state_next = S_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mau_op <= '0;
            mau_a1 <= '0;
            mau_a2 <= '0;
            mau_b1 <= '0;
            mau_b2 <= '0;
        end else if (push) begin
            mau_op <= req_op[{winner, 2'b00} +: 4];
            mau_a1 <= req_a1[{winner, 2'b00} +: 4];
            mau_a2 <= req_a2[{winner, 2'b00} +: 4];
            mau_b1 <= req_b1[{winner, 2'b00} +: 4];
            mau_b2 <= req_b2[{winner, 2'b00} +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else begin
`ifdef MAU_ARB_FIXED_PRIO_EN
            rr_ptr <= '0;
`else
            if (push) begin
                rr_ptr <= (winner == TAG_W'(NUM_REQ - 1)) ? '0 : winner + TAG_W'(1);
            end
`endif
        end
    end

    // Response routing: results belong to the oldest tag; orphans are drained without a target.
    always_comb begin
        rsp_valid = '0;
        if (alu_res_valid && !fifo_empty) begin
            rsp_valid[head_tag] = 1'b1;
        end
        alu_res_ready = fifo_empty ? alu_res_valid : rsp_ready[head_tag];
        rsp_data      = alu_res;
        rsp_carry     = alu_carry;
    end

    assign pop = alu_res_valid && alu_res_ready && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (alu_res_valid && fifo_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mau_req_arbiter_4b.sv
// Self-checking bench for mau_req_arbiter_4b: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the arbiter's rules.
module tb_mau_req_arbiter_4b;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1);

    logic                 clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_op, req_a1, req_a2, req_b1, req_b2;
    logic                 mau_valid;
    logic                 mau_ready;
    logic [3:0]           mau_op, mau_a1, mau_a2, mau_b1, mau_b2;
    logic                 alu_res_valid;
    logic [9:0]           alu_res;
    logic                 alu_carry;
    logic                 alu_res_ready;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [NUM_REQ-1:0]   rsp_ready;
    logic [9:0]           rsp_data;
    logic                 rsp_carry;
    logic [CNT_W-1:0]     outstanding;
    logic                 err_orphan;

    mau_req_arbiter_4b #(.NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a1(req_a1), .req_a2(req_a2), .req_b1(req_b1), .req_b2(req_b2),
        .mau_valid(mau_valid), .mau_ready(mau_ready),
        .mau_op(mau_op), .mau_a1(mau_a1), .mau_a2(mau_a2), .mau_b1(mau_b1), .mau_b2(mau_b2),
        .alu_res_valid(alu_res_valid), .alu_res(alu_res), .alu_carry(alu_carry),
        .alu_res_ready(alu_res_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Reference model: slot contents, pending-tag queue, arbitration pointer, sticky orphan flag.
    bit         m_full;
    logic [3:0] m_op, m_a1, m_a2, m_b1, m_b2;
    int         m_rr;
    int         m_q[$];
    bit         m_orph;
    int         last_grant;
    int         grants[6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_op = '0; m_a1 = '0; m_a2 = '0; m_b1 = '0; m_b2 = '0;
        m_rr = 0;
        m_q.delete();
        m_orph = 1'b0;
        last_grant = -1;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_op = '0; req_a1 = '0; req_a2 = '0; req_b1 = '0; req_b2 = '0;
        mau_ready = 1'b0;
        alu_res_valid = 1'b0;
        alu_res = '0;
        alu_carry = 1'b0;
        rsp_ready = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] op, input logic [3:0] a1,
                           input logic [3:0] a2, input logic [3:0] b1, input logic [3:0] b2);
        req_valid[i]     = v;
        req_op[4*i +: 4] = op;
        req_a1[4*i +: 4] = a1;
        req_a2[4*i +: 4] = a2;
        req_b1[4*i +: 4] = b1;
        req_b2[4*i +: 4] = b2;
    endtask

    function automatic int pick();
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            int idx;
            idx = (m_rr + k) % int'(NUM_REQ);
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock: check combinational outputs, advance the model at the edge, check registered outputs.
    task automatic step_cycle();
        int               w;
        int               head;
        bit               nonempty;
        bit               can;
        logic [NUM_REQ-1:0] exp_rr;
        logic [NUM_REQ-1:0] exp_rv;
        logic             exp_ar;
        logic [3:0]       c_op, c_a1, c_a2, c_b1, c_b2;
        #1;
        nonempty = (m_q.size() != 0);
        head     = nonempty ? m_q[0] : 0;
        w        = pick();
        can      = (w >= 0) && (m_q.size() < int'(MAX_OUT)) && (!m_full || mau_ready);
        exp_rr   = '0;
        exp_rv   = '0;
        if (can) exp_rr[w] = 1'b1;
        if (alu_res_valid && nonempty) exp_rv[head] = 1'b1;
        exp_ar   = nonempty ? rsp_ready[head] : alu_res_valid;
        chk("req_ready", 32'(req_ready), 32'(exp_rr));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        chk("alu_res_ready", 32'(alu_res_ready), 32'(exp_ar));
        chk("rsp_data", 32'(rsp_data), 32'(alu_res));
        chk("rsp_carry", 32'(rsp_carry), 32'(alu_carry));
        last_grant = can ? w : -1;
        if (can) begin
            c_op = req_op[4*w +: 4]; c_a1 = req_a1[4*w +: 4]; c_a2 = req_a2[4*w +: 4];
            c_b1 = req_b1[4*w +: 4]; c_b2 = req_b2[4*w +: 4];
        end else begin
            c_op = '0; c_a1 = '0; c_a2 = '0; c_b1 = '0; c_b2 = '0;
        end
        @(posedge clk);
        if (alu_res_valid) begin
            if (nonempty) begin
                if (exp_ar) void'(m_q.pop_front());
            end else begin
                m_orph = 1'b1;
            end
        end
        if (can) begin
            m_q.push_back(w);
            m_full = 1'b1;
            m_op = c_op; m_a1 = c_a1; m_a2 = c_a2; m_b1 = c_b1; m_b2 = c_b2;
`ifdef MAU_ARB_FIXED_PRIO_EN
            m_rr = 0;
`else
            m_rr = (w + 1) % int'(NUM_REQ);
`endif
        end else if (m_full && mau_ready) begin
            m_full = 1'b0;
        end
        #1;
        chk("mau_valid", 32'(mau_valid), 32'(m_full));
        if (m_full) begin
            chk("mau_op", 32'(mau_op), 32'(m_op));
            chk("mau_a1", 32'(mau_a1), 32'(m_a1));
            chk("mau_a2", 32'(mau_a2), 32'(m_a2));
            chk("mau_b1", 32'(mau_b1), 32'(m_b1));
            chk("mau_b2", 32'(mau_b2), 32'(m_b2));
        end
        chk("outstanding", 32'(outstanding), 32'(m_q.size()));
        chk("err_orphan", 32'(err_orphan), 32'(m_orph));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_mau_valid", 32'(mau_valid), 32'd0);
        chk("rst_mau_op", 32'(mau_op), 32'd0);
        chk("rst_mau_b2", 32'(mau_b2), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_err_orphan", 32'(err_orphan), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_res_ready", 32'(alu_res_ready), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        do_reset();

        // Single request, then its result.
        set_req(0, 1'b1, 4'd3, 4'd1, 4'd2, 4'd4, 4'd5);
        mau_ready = 1'b1;
        #1 chk("single_req_ready", 32'(req_ready), 32'h1);
        step_cycle();
        chk("single_mau_valid", 32'(mau_valid), 32'd1);
        chk("single_mau_op", 32'(mau_op), 32'd3);
        chk("single_mau_a1", 32'(mau_a1), 32'd1);
        chk("single_mau_a2", 32'(mau_a2), 32'd2);
        chk("single_mau_b1", 32'(mau_b1), 32'd4);
        chk("single_mau_b2", 32'(mau_b2), 32'd5);
        chk("single_outstanding", 32'(outstanding), 32'd1);
        req_valid = '0;
        alu_res_valid = 1'b1; alu_res = 10'h12A; alu_carry = 1'b1; rsp_ready = 2'b01;
        #1;
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_data", 32'(rsp_data), 32'h12A);
        chk("single_rsp_carry", 32'(rsp_carry), 32'd1);
        step_cycle();
        chk("single_outstanding_after", 32'(outstanding), 32'd0);
        alu_res_valid = 1'b0;
        step_cycle();

        // Fairness: both requesters continuously valid, one result per cycle.
        do_reset();
        set_req(0, 1'b1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1);
        set_req(1, 1'b1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2);
        mau_ready = 1'b1; rsp_ready = '1;
        step_cycle();
        grants[0] = last_grant;
        alu_res_valid = 1'b1;
        for (int k = 1; k < 6; k++) begin
            alu_res = 10'(k * 37);
            alu_carry = k[0];
            step_cycle();
            grants[k] = last_grant;
        end
        for (int k = 0; k < 6; k++) begin
`ifdef MAU_ARB_FIXED_PRIO_EN
            chk("fixed_grant", 32'(grants[k]), 32'd0);
`else
            chk("fair_grant", 32'(grants[k]), 32'(k % 2));
`endif
        end
        req_valid = '0;
        step_cycle();
        alu_res_valid = 1'b0;
        step_cycle();

        // Backpressure: slot held for five cycles while mau_ready is low.
        do_reset();
        set_req(0, 1'b1, 4'h7, 4'h1, 4'h2, 4'h3, 4'h4);
        mau_ready = 1'b1;
        step_cycle();
        set_req(0, 1'b1, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9);
        set_req(1, 1'b1, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9);
        mau_ready = 1'b0;
        repeat (5) begin
            step_cycle();
            chk("bp_no_grant", 32'(last_grant), 32'(-1));
            chk("bp_mau_op", 32'(mau_op), 32'h7);
            chk("bp_mau_b2", 32'(mau_b2), 32'h4);
        end
        mau_ready = 1'b1;
        step_cycle();
`ifdef MAU_ARB_FIXED_PRIO_EN
        chk("bp_resume_grant", 32'(last_grant), 32'd0);
`else
        chk("bp_resume_grant", 32'(last_grant), 32'd1);
        chk("bp_resume_op", 32'(mau_op), 32'h5);
`endif
        chk("bp_outstanding", 32'(outstanding), 32'd2);
        req_valid = '0;
        alu_res_valid = 1'b1; rsp_ready = '1;
        repeat (2) step_cycle();
        alu_res_valid = 1'b0;
        step_cycle();

        // FIFO full: accept blocked at four pending tags, even during a pop.
        do_reset();
        set_req(0, 1'b1, 4'hA, 4'h0, 4'h1, 4'h2, 4'h3);
        set_req(1, 1'b1, 4'hB, 4'h4, 4'h5, 4'h6, 4'h7);
        mau_ready = 1'b1; rsp_ready = '1;
        repeat (4) step_cycle();
        chk("full_outstanding", 32'(outstanding), 32'd4);
        repeat (2) begin
            step_cycle();
            chk("full_no_grant", 32'(last_grant), 32'(-1));
        end
        alu_res_valid = 1'b1; alu_res = 10'h3FF;
        step_cycle();
        chk("full_pop_no_grant", 32'(last_grant), 32'(-1));
        chk("full_after_pop", 32'(outstanding), 32'd3);
        alu_res_valid = 1'b0;
        step_cycle();
        chk("full_regrant", 32'(last_grant), 32'd0);
        chk("full_refill", 32'(outstanding), 32'd4);
        req_valid = '0;
        alu_res_valid = 1'b1;
        repeat (4) step_cycle();
        chk("full_drained", 32'(outstanding), 32'd0);

        // Orphan result with nothing pending.
        rsp_ready = '0; alu_res_valid = 1'b1; alu_res = 10'h055;
        #1;
        chk("orphan_alu_ready", 32'(alu_res_ready), 32'd1);
        chk("orphan_rsp_valid", 32'(rsp_valid), 32'd0);
        step_cycle();
        chk("orphan_flag", 32'(err_orphan), 32'd1);
        alu_res_valid = 1'b0;
        repeat (3) step_cycle();
        chk("orphan_sticky", 32'(err_orphan), 32'd1);

        // Reset mid-operation: slot full with two pending tags.
        set_req(0, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5);
        set_req(1, 1'b1, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA);
        mau_ready = 1'b1;
        repeat (2) step_cycle();
        mau_ready = 1'b0;
        req_valid = '0;
        step_cycle();
        chk("midop_pre_valid", 32'(mau_valid), 32'd1);
        chk("midop_pre_outstanding", 32'(outstanding), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("midop_mau_valid", 32'(mau_valid), 32'd0);
        chk("midop_outstanding", 32'(outstanding), 32'd0);
        chk("midop_err_orphan", 32'(err_orphan), 32'd0);
        model_reset();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MAU_ARB_FIXED_PRIO_EN
        set_req(0, 1'b1, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3);
        set_req(1, 1'b1, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4);
        mau_ready = 1'b1; rsp_ready = '1;
        step_cycle();
        alu_res_valid = 1'b1;
        repeat (4) begin
            step_cycle();
            chk("fixed_req0_wins", 32'(last_grant), 32'd0);
        end
`endif

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            req_valid = NUM_REQ'($urandom);
            req_op = (4*NUM_REQ)'($urandom); req_a1 = (4*NUM_REQ)'($urandom);
            req_a2 = (4*NUM_REQ)'($urandom); req_b1 = (4*NUM_REQ)'($urandom);
            req_b2 = (4*NUM_REQ)'($urandom);
            mau_ready = ($urandom_range(0, 3) != 0);
            alu_res_valid = ($urandom_range(0, 2) == 0);
            alu_res = 10'($urandom);
            alu_carry = 1'($urandom);
            rsp_ready = NUM_REQ'($urandom);
            step_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
